// File: rtl/gpio_blink_monitor.sv
// Blink monitor for the Caravel mgmt gpio pad: synchronize, glitch-filter, count falling edges, flag pass/timeout.
// Define GPIO_MON_CHECKBITS_EN to build the mprj_io[31:16] checkbits change tracker.
module gpio_blink_monitor #(
    parameter int BLINKS         = 10,
    parameter int TIMEOUT_CYCLES = 25000,
    parameter int MIN_PULSE      = 4,
    parameter int CNT_W          = 16
) (
    input  logic             clock,
    input  logic             FPGA_rst,
    input  logic             gpio_in,
    input  logic [15:0]      checkbits_in,
    input  logic             start,
    output logic             busy,
    output logic             pass,
    output logic             fail,
    output logic [7:0]       blink_count,
    output logic [CNT_W-1:0] last_high_cycles,
    output logic [15:0]      checkbits_last,
    output logic [7:0]       checkbits_changes
);

    typedef enum logic [2:0] {IDLE, WAIT_HI, WAIT_LO, PASS, FAIL} state_t;

    localparam logic [CNT_W-1:0] FILT_LAST  = CNT_W'(MIN_PULSE - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [7:0]       LAST_BLINK = 8'(BLINKS - 1);

    // ---------------- gpio input path ----------------
    logic [1:0]       gpio_pipe;  // [0] meta, [1] synchronized
    logic             filt, filt_d;
    logic [CNT_W-1:0] filt_cnt;
    logic             rise, fall;

    always_ff @(posedge clock) begin
        if (FPGA_rst) begin
            gpio_pipe <= '0;
        end else begin
            gpio_pipe <= {gpio_pipe[0], gpio_in};
        end
    end

    // Level is accepted only after MIN_PULSE consecutive disagreeing samples.
    always_ff @(posedge clock) begin
        if (FPGA_rst) begin
            filt     <= 1'b0;
            filt_d   <= 1'b0;
            filt_cnt <= '0;
        end else begin
            filt_d <= filt;
            if (gpio_pipe[1] != filt) begin
                if (filt_cnt == FILT_LAST) begin
                    filt     <= gpio_pipe[1];
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + CNT_W'(1);
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    assign rise = filt & ~filt_d;
    assign fall = ~filt & filt_d;

    // ---------------- control FSM ----------------
    state_t           state, state_nxt;
    logic [CNT_W-1:0] tcnt;
    logic [CNT_W-1:0] width;
    logic             in_wait, arm, timeout, final_fall;

    assign in_wait    = (state == WAIT_HI) || (state == WAIT_LO);
    assign arm        = start && !in_wait;
    assign timeout    = (tcnt == TO_LAST);
    assign final_fall = fall && (blink_count == LAST_BLINK);

    always_ff @(posedge clock) begin
        if (FPGA_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The final blink is tested ahead of the timeout so a coincident edge still passes.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, PASS, FAIL: begin
                if (start) state_nxt = WAIT_HI;
            end
            WAIT_HI: begin
                if (timeout)   state_nxt = FAIL;
                else if (rise) state_nxt = WAIT_LO;
            end
            WAIT_LO: begin
                if (final_fall)   state_nxt = PASS;
                else if (timeout) state_nxt = FAIL;
                else if (fall)    state_nxt = WAIT_HI;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- datapath and registered status ----------------
    always_ff @(posedge clock) begin
        if (FPGA_rst) begin
            busy             <= 1'b0;
            pass             <= 1'b0;
            fail             <= 1'b0;
            blink_count      <= '0;
            last_high_cycles <= '0;
            tcnt             <= '0;
            width            <= '0;
        end else begin
            busy <= (state_nxt == WAIT_HI) || (state_nxt == WAIT_LO);
            pass <= (state_nxt == PASS);
            fail <= (state_nxt == FAIL);
            if (arm) begin
                blink_count      <= '0;
                last_high_cycles <= '0;
                tcnt             <= '0;
            end else begin
                if (in_wait) tcnt <= tcnt + CNT_W'(1);
                if (state == WAIT_HI && rise) width <= CNT_W'(1);
                if (state == WAIT_LO) begin
                    if (fall) begin
                        last_high_cycles <= width;
                        blink_count      <= blink_count + 8'd1;
                    end else if (width != CNT_MAX) begin
                        width <= width + CNT_W'(1);
                    end
                end
            end
        end
    end

    // ---------------- checkbits tracker ----------------
`ifdef GPIO_MON_CHECKBITS_EN
    logic [15:0] cb_meta, cb_sync, cb_prev;

    // A new value must be seen on two consecutive synchronized samples to count.
    always_ff @(posedge clock) begin
        if (FPGA_rst) begin
            cb_meta           <= '0;
            cb_sync           <= '0;
            cb_prev           <= '0;
            checkbits_last    <= '0;
            checkbits_changes <= '0;
        end else begin
            cb_meta <= checkbits_in;
            cb_sync <= cb_meta;
            cb_prev <= cb_sync;
            if (cb_sync == cb_prev && cb_sync != checkbits_last) begin
                checkbits_last <= cb_sync;
                if (checkbits_changes != 8'hFF) checkbits_changes <= checkbits_changes + 8'd1;
            end
        end
    end
`else
    logic cb_unused;
    assign cb_unused         = ^checkbits_in;
    assign checkbits_last    = '0;
    assign checkbits_changes = '0;
`endif

endmodule

// File: tb/tb_gpio_blink_monitor.sv
// Randomized + directed bench for gpio_blink_monitor against a cycle-level behavioural model.
module tb_gpio_blink_monitor;
    localparam int BLINKS = 10;
    localparam int TO     = 25000;
    localparam int MP     = 4;
    localparam int CW     = 16;

    logic          clock = 1'b0;
    logic          FPGA_rst, gpio_in, start;
    logic [15:0]   checkbits_in;
    logic          busy, pass, fail;
    logic [7:0]    blink_count;
    logic [CW-1:0] last_high_cycles;
    logic [15:0]   checkbits_last;
    logic [7:0]    checkbits_changes;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    gpio_blink_monitor #(.BLINKS(BLINKS), .TIMEOUT_CYCLES(TO), .MIN_PULSE(MP), .CNT_W(CW)) dut (
        .clock(clock), .FPGA_rst(FPGA_rst), .gpio_in(gpio_in), .checkbits_in(checkbits_in),
        .start(start), .busy(busy), .pass(pass), .fail(fail), .blink_count(blink_count),
        .last_high_cycles(last_high_cycles), .checkbits_last(checkbits_last),
        .checkbits_changes(checkbits_changes)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Session flags instead of states: armed, waiting for a fall, cycles since arm.
    bit          m_busy, m_pass, m_fail, m_want_fall, m_filt, p_rise, p_fall;
    int          m_cnt, m_lhc, m_width, m_elapsed;
    bit          g_h[2];         // raw gpio samples from 1 and 2 edges back
    bit          m_win[$];       // last MP synchronized samples
    logic [15:0] cb_h[3];        // raw checkbits from 1,2,3 edges back
    logic [15:0] cb_last;
    int          cb_ch;

    function automatic void model_reset();
        m_busy = 0; m_pass = 0; m_fail = 0; m_want_fall = 0; m_filt = 0;
        p_rise = 0; p_fall = 0; m_cnt = 0; m_lhc = 0; m_width = 0; m_elapsed = 0;
        g_h[0] = 0; g_h[1] = 0;
        m_win.delete();
        for (int i = 0; i < MP; i++) m_win.push_back(1'b0);
        for (int i = 0; i < 3; i++) cb_h[i] = '0;
        cb_last = '0; cb_ch = 0;
    endfunction

    function automatic void model_step();
        bit s, flip;
        if (FPGA_rst) begin
            model_reset();
            return;
        end
        if (start && !m_busy) begin
            m_busy = 1; m_pass = 0; m_fail = 0; m_want_fall = 0;
            m_cnt = 0; m_lhc = 0; m_elapsed = 0;
        end else if (m_busy) begin
            if (!m_want_fall) begin
                if (p_rise) begin m_want_fall = 1; m_width = 1; end
            end else if (p_fall) begin
                m_lhc = m_width;
                m_cnt++;
                if (m_cnt == BLINKS) begin m_pass = 1; m_busy = 0; end
                else m_want_fall = 0;
            end else if (m_width < (1 << CW) - 1) begin
                m_width++;
            end
            if (m_busy) begin
                if (m_elapsed == TO - 1) begin m_fail = 1; m_busy = 0; end
                else m_elapsed++;
            end
        end
        // filter: flip once the last MP synchronized samples all disagree
        s = g_h[1];
        m_win.push_back(s);
        void'(m_win.pop_front());
        flip = 1;
        foreach (m_win[i]) if (m_win[i] == m_filt) flip = 0;
        p_rise = flip && s;
        p_fall = flip && !s;
        if (flip) m_filt = s;
        g_h[1] = g_h[0];
        g_h[0] = gpio_in;
`ifdef GPIO_MON_CHECKBITS_EN
        if (cb_h[1] == cb_h[2] && cb_h[1] != cb_last) begin
            cb_last = cb_h[1];
            if (cb_ch < 255) cb_ch++;
        end
`endif
        cb_h[2] = cb_h[1];
        cb_h[1] = cb_h[0];
        cb_h[0] = checkbits_in;
    endfunction

    function automatic logic [63:0] model_vec();
        return {13'b0, m_busy, m_pass, m_fail, 8'(m_cnt), 16'(m_lhc), cb_last, 8'(cb_ch)};
    endfunction

    function automatic logic [63:0] dut_vec();
        return {13'b0, busy, pass, fail, blink_count, last_high_cycles, checkbits_last, checkbits_changes};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        chk("cycle", dut_vec(), model_vec());
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse(input int hi, input int lo);
        gpio_in = 1'b1; run(hi);
        gpio_in = 1'b0; run(lo);
    endtask

    task automatic arm();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    initial begin
        int lat, hold;
        FPGA_rst = 1'b1; gpio_in = 1'b0; start = 1'b0; checkbits_in = '0;
        model_reset();
        run(5);
        chk("reset_outs", {busy, pass, fail, blink_count, last_high_cycles, checkbits_last, checkbits_changes}, '0);
        FPGA_rst = 1'b0;

        // checkbits: two real changes, one single-cycle spike
        checkbits_in = 16'h0000; run(20);
        checkbits_in = 16'h0102; run(20);
        checkbits_in = 16'hFFFF; run(1);
        checkbits_in = 16'h0103; run(20);
`ifdef GPIO_MON_CHECKBITS_EN
        chk("cb_last", checkbits_last, 16'h0103);
        chk("cb_changes", checkbits_changes, 2);
`else
        chk("cb_last_tied", checkbits_last, 16'h0000);
        chk("cb_changes_tied", checkbits_changes, 0);
`endif

        // ten 50/50 blinks to pass, measuring latency from the capturing edge
        arm();
        lat = -1;
        for (int i = 1; i <= BLINKS; i++) begin
            gpio_in = 1'b1; run(50);
            gpio_in = 1'b0;
            for (int j = 1; j <= 50; j++) begin
                tick();
                if (pass && lat < 0) lat = j - 1;
            end
            chk("t1_count", blink_count, i);
        end
        chk("t1_pass_latency", lat, 2 + MP);
        chk("t1_flags", {busy, pass, fail}, 3'b010);
        chk("t1_width", last_high_cycles, 50);

        // glitches shorter than MP are dropped
        arm();
        gpio_in = 1'b1; run(2);  gpio_in = 1'b0; run(10);
        gpio_in = 1'b1; run(3);  gpio_in = 1'b0; run(10);
        pulse(50, 50);
        chk("t2_count", blink_count, 1);
        chk("t2_width", last_high_cycles, 50);
        arm();
        chk("t2_start_busy_ignored", {busy, blink_count}, {1'b1, 8'd1});

        // reset after blink 5 aborts, later pulses without start are ignored
        repeat (4) pulse(30, 30);
        chk("t4_count5", blink_count, 5);
        FPGA_rst = 1'b1; tick(); FPGA_rst = 1'b0;
        chk("t4_reset_outs", {busy, pass, fail, blink_count, last_high_cycles}, '0);
        repeat (3) pulse(20, 20);
        chk("t4_no_arm", {busy, blink_count}, '0);

        // timeout with gpio held low
        arm();
        lat = -1;
        for (int j = 1; j <= TO + 20 && lat < 0; j++) begin
            tick();
            if (fail) lat = j;
        end
        chk("t3_fail_time", lat, TO);
        chk("t3_after_fail", {busy, pass, blink_count}, '0);
        arm();
        chk("t3_rearm", {busy, fail}, 2'b10);

        // final filtered fall lands on the timeout cycle: pass wins
        repeat (BLINKS - 1) pulse(50, 50);
        gpio_in = 1'b1;
        run(TO - 3 - MP - (BLINKS - 1) * 100);
        gpio_in = 1'b0;
        run(MP + 3);
        chk("t5_coincide", {busy, pass, fail, blink_count}, {3'b010, 8'(BLINKS)});

        // random traffic: variable pulse widths, stray starts, rare resets, checkbits churn
        arm();
        hold = 0;
        for (int c = 0; c < 4000; c++) begin
            if (hold == 0) begin
                gpio_in = ~gpio_in;
                hold = $urandom_range(1, 14);
            end
            hold--;
            start    = ($urandom_range(0, 199) == 0);
            FPGA_rst = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 29) == 0)
                checkbits_in = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            tick();
        end
        FPGA_rst = 1'b0; start = 1'b0;
        run(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
